// File: rtl/tdm_demux4.sv
// Four-channel serial TDM demultiplexer with frame-sync tracking.
// Optional TDM_DEMUX_ERRCNT_EN adds a saturating sync-error counter.
module tdm_demux4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       frame_sync,
  output logic [7:0] out_a,
  output logic [7:0] out_b,
  output logic [7:0] out_c,
  output logic [7:0] out_d,
  output logic [3:0] out_valid,
  output logic       locked,
  output logic       sync_err
`ifdef TDM_DEMUX_ERRCNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  typedef enum logic {
    HUNT,
    LOCKED
  } state_t;

  state_t state, state_nx;
  logic [1:0] slot, slot_nx;
  logic [2:0] frame, frame_nx;
  logic [3:0][7:0] sr, sr_nx;
  logic [3:0] pend, pend_nx;
  logic err_nx;

  always_comb begin
    state_nx = state;
    slot_nx  = slot;
    frame_nx = frame;
    sr_nx    = sr;
    pend_nx  = '0;
    err_nx   = 1'b0;
    unique case (state)
      HUNT: begin
        if (frame_sync) begin
          sr_nx    = '0;
          sr_nx[0] = {7'd0, din};
          slot_nx  = 2'd1;
          frame_nx = 3'd0;
          state_nx = LOCKED;
        end
      end
      LOCKED: begin
        if (frame_sync && slot != 2'd0) begin
          // restart alignment at this bit
          err_nx   = 1'b1;
          sr_nx    = '0;
          sr_nx[0] = {7'd0, din};
          slot_nx  = 2'd1;
          frame_nx = 3'd0;
        end else if (!frame_sync && slot == 2'd0) begin
          err_nx   = 1'b1;
          sr_nx    = '0;
          slot_nx  = 2'd0;
          frame_nx = 3'd0;
          state_nx = HUNT;
        end else begin
          sr_nx[slot] = {sr[slot][6:0], din};
          if (frame == 3'd7) pend_nx[slot] = 1'b1;
          slot_nx = slot + 2'd1;
          if (slot == 2'd3) frame_nx = frame + 3'd1;
        end
      end
    endcase
  end

  // completed bytes publish one edge after their last bit
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      slot      <= 2'd0;
      frame     <= 3'd0;
      sr        <= '0;
      pend      <= '0;
      out_a     <= 8'h00;
      out_b     <= 8'h00;
      out_c     <= 8'h00;
      out_d     <= 8'h00;
      out_valid <= 4'b0000;
      sync_err  <= 1'b0;
    end else begin
      state     <= state_nx;
      slot      <= slot_nx;
      frame     <= frame_nx;
      sr        <= sr_nx;
      pend      <= pend_nx;
      out_valid <= pend;
      sync_err  <= err_nx;
      if (pend[0]) out_a <= sr[0];
      if (pend[1]) out_b <= sr[1];
      if (pend[2]) out_c <= sr[2];
      if (pend[3]) out_d <= sr[3];
    end
  end

  assign locked = (state == LOCKED);

`ifdef TDM_DEMUX_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= 8'h00;
    end else if (err_nx && err_cnt != 8'hFF) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tdm_demux4.sv
// Randomised scoreboard bench for tdm_demux4.
// Build with TDM_DEMUX_ERRCNT_EN to also cover the error counter.
module tb_tdm_demux4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b0;
  logic       frame_sync = 1'b0;
  logic [7:0] out_a, out_b, out_c, out_d;
  logic [3:0] out_valid;
  logic       locked, sync_err;
`ifdef TDM_DEMUX_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  tdm_demux4 dut (
    .clk(clk),
    .rst(rst),
    .din(din),
    .frame_sync(frame_sync),
    .out_a(out_a),
    .out_b(out_b),
    .out_c(out_c),
    .out_d(out_d),
    .out_valid(out_valid),
    .locked(locked),
    .sync_err(sync_err)
`ifdef TDM_DEMUX_ERRCNT_EN
    ,
    .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int stamp;
    int ch;
    int data;
  } ev_t;

  ev_t bq[$];
  ev_t eq[$];
  ev_t me;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit mon_en = 0;
  bit chk_lock = 0;

  // reference: position within a 32-bit byte period
  bit m_locked = 0;
  int m_pos = 0;
  int m_acc[4];
  int m_errcnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, got, exp, cyc);
    end
  endtask

  function automatic int outsel(input int ch);
    case (ch)
      0: return int'(out_a);
      1: return int'(out_b);
      2: return int'(out_c);
      default: return int'(out_d);
    endcase
  endfunction

  task automatic clear_acc();
    for (int i = 0; i < 4; i++) m_acc[i] = 0;
  endtask

  task automatic push_err(input int n);
    eq.push_back('{n, 0, 0});
    if (m_errcnt < 255) m_errcnt++;
  endtask

  task automatic model(input bit r, input bit d, input bit f,
                       input int n);
    int s;
    if (r) begin
      m_locked = 0;
      m_pos = 0;
      m_errcnt = 0;
      clear_acc();
      while (bq.size() > 0 && bq[bq.size()-1].stamp >= n)
        bq.delete(bq.size()-1);
      return;
    end
    if (!m_locked) begin
      if (f) begin
        m_locked = 1;
        clear_acc();
        m_acc[0] = int'(d);
        m_pos = 1;
      end
      return;
    end
    s = m_pos % 4;
    if (f && s != 0) begin
      push_err(n);
      clear_acc();
      m_acc[0] = int'(d);
      m_pos = 1;
    end else if (!f && s == 0) begin
      push_err(n);
      clear_acc();
      m_pos = 0;
      m_locked = 0;
    end else begin
      m_acc[s] = ((m_acc[s] * 2) + int'(d)) % 256;
      if (m_pos >= 28) bq.push_back('{n + 1, s, m_acc[s]});
      m_pos = (m_pos + 1) % 32;
    end
  endtask

  task automatic step(input bit r, input bit d, input bit f);
    @(negedge clk);
    if (chk_lock) check("locked", int'(locked), int'(m_locked));
    rst = r;
    din = d;
    frame_sync = f;
    model(r, d, f, cyc + 1);
  endtask

  task automatic send_bits(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3,
                           input int nbits, input int err_rate);
    logic [7:0] bb[4];
    bit f;
    bb[0] = b0; bb[1] = b1; bb[2] = b2; bb[3] = b3;
    for (int k = 0; k < nbits; k++) begin
      f = (k % 4 == 0);
      if (err_rate > 0 && $urandom_range(0, err_rate - 1) == 0) f = !f;
      step(0, bb[k % 4][7 - k / 4], f);
    end
  endtask

  task automatic send_rand(input int nbits, input int err_rate);
    send_bits(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
              nbits, err_rate);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid != 4'b0000) begin
        if (bq.size() == 0) begin
          check("spurious_valid", int'(out_valid), 0);
        end else begin
          me = bq.pop_front();
          check("valid_cycle", cyc, me.stamp);
          check("valid_chan", int'(out_valid), 1 << me.ch);
          check("byte", outsel(me.ch), me.data);
        end
      end else if (bq.size() > 0 && bq[0].stamp <= cyc) begin
        me = bq.pop_front();
        check("missed_valid", int'(out_valid), 1 << me.ch);
      end
      if (sync_err) begin
        if (eq.size() == 0) begin
          check("spurious_sync_err", int'(sync_err), 0);
        end else begin
          me = eq.pop_front();
          check("sync_err_cycle", cyc, me.stamp);
        end
      end else if (eq.size() > 0 && eq[0].stamp <= cyc) begin
        me = eq.pop_front();
        check("missed_sync_err", int'(sync_err), 1);
      end
    end
  end

  initial begin
    step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    chk_lock = 1;
    @(negedge clk);
    check("rst_out_a", int'(out_a), 0);
    check("rst_out_b", int'(out_b), 0);
    check("rst_out_c", int'(out_c), 0);
    check("rst_out_d", int'(out_d), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_sync_err", int'(sync_err), 0);
    mon_en = 1;

    send_bits(8'hA5, 8'h3C, 8'hFF, 8'h01, 32, 0);
    send_rand(32, 0);
    // misplaced sync lands on slot 2 of frame 3
    send_rand(14, 0);
    send_rand(32, 0);
    // missing sync at a slot-0 bit
    step(0, 1'($urandom_range(0, 1)), 0);
    repeat (3) step(0, 1'($urandom_range(0, 1)), 0);
    send_rand(32, 0);
    // reset mid-byte in frame 5
    send_rand(22, 0);
    step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    send_rand(32, 0);
    for (int i = 0; i < 8; i++) begin
      send_rand(32, 40);
      if ($urandom_range(0, 1) == 1)
        repeat ($urandom_range(1, 5))
          step(0, 1'($urandom_range(0, 1)), 0);
    end

`ifdef TDM_DEMUX_ERRCNT_EN
    repeat (300) step(0, 1'($urandom_range(0, 1)), 1);
    @(negedge clk);
    check("err_cnt_sat_model", int'(err_cnt), m_errcnt);
    check("err_cnt_sat", int'(err_cnt), 255);
    step(1, 0, 0);
    @(negedge clk);
    check("err_cnt_rst", int'(err_cnt), 0);
`endif

    repeat (6) step(0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The port list SHALL be, in order:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- din  input  1  serial TDM bit, one bit per clk
- frame_sync  input  1  high during the slot-0 bit of each frame
- out_a  output  8  channel 0 byte
- out_b  output  8  channel 1 byte
- out_c  output  8  channel 2 byte
- out_d  output  8  channel 3 byte
- out_valid  output  4  one-cycle pulse per channel; bit k = channel k
- locked  output  1  1 when frame alignment is held
- sync_err  output  1  one-cycle pulse on an alignment fault
REQ-003 The block SHALL have no parameters; frame length is fixed at 4 slots and byte length at 8 frames.

Function
REQ-004 The frame SHALL be 4 consecutive bits. The slot-k bit SHALL belong to channel k (0=a, 1=b, 2=c, 3=d).
REQ-005 The FSM SHALL have two states, HUNT and LOCKED. The block SHALL enter HUNT on reset.
REQ-006 HUNT behaviour:
- frame_sync=0: din ignored.
- frame_sync=1: din captured as channel 0 bit; slot counter becomes 1; frame counter becomes 0; next state LOCKED.
REQ-007 LOCKED behaviour:
- Each cycle, din is shifted MSB-first into the shift register of the channel selected by the 2-bit slot counter.
- The slot counter then increments and wraps 3->0.
REQ-008 The frame counter SHALL be 3-bit, incremented when slot 3 is captured, and SHALL wrap 7->0.
REQ-009 Byte completion:
- When channel k's slot is captured in frame 7, the completed byte SHALL load into out_<k> and out_valid[k] SHALL pulse high for exactly one cycle.
- Both happen on the clock edge after that bit's capture edge (latency 1 cycle from the last bit).
REQ-010 out_a..out_d SHALL hold their value until the next completed byte for that channel.
REQ-011 Misplaced sync (LOCKED, frame_sync=1 while slot counter is not 0):
- sync_err pulses for one cycle.
- All partial shift registers are discarded and the frame counter becomes 0.
- The current bit is captured as channel 0 bit 7 (MSB) of a new frame; slot counter becomes 1.
- State stays LOCKED.
REQ-012 Missing sync (LOCKED, slot counter 0, frame_sync=0):
- sync_err pulses for one cycle.
- All partial data are discarded; the bit is not captured.
- Next state HUNT; locked falls on the same edge.
REQ-013 frame_sync=1 at slot 0 in LOCKED SHALL be the normal case and SHALL raise no error.
REQ-014 locked SHALL be 1 exactly while the state is LOCKED.
REQ-015 At most one out_valid bit SHALL be high in any cycle.

Reset
REQ-016 When rst=1 at a clock edge, the block SHALL set:
- state HUNT
- slot counter 0, frame counter 0
- all shift registers 0
- out_a..out_d = 8'h00
- out_valid = 4'b0000
- locked = 0, sync_err = 0
REQ-017 rst SHALL take priority over all other inputs. Reset mid-byte SHALL discard partial data with no out_valid pulse.

Configuration
REQ-018 When macro TDM_DEMUX_ERRCNT_EN is defined:
- Extra output err_cnt (8-bit) counts sync_err pulses and saturates at 8'hFF.
- rst clears err_cnt to 0.
REQ-019 Without TDM_DEMUX_ERRCNT_EN, err_cnt and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-020 Reset: hold rst 2 cycles with random din/frame_sync -> all outputs 0, locked=0.
REQ-021 Clean stream: sync each frame, channels a/b/c/d carry 8'hA5/8'h3C/8'hFF/8'h01 MSB-first over 32 cycles ->
- out_valid pulses 0001, 0010, 0100, 1000 on consecutive cycles.
- Bytes equal the sent values.
- sync_err never pulses.
REQ-022 Misplaced sync: frame_sync at slot 2 in frame 3 -> sync_err pulse, no out_valid for 8 frames. The next full 32 bits then decode correctly.
REQ-023 Missing sync: frame_sync=0 at a slot-0 bit -> sync_err pulse, locked=0 next cycle. Re-alignment on the next frame_sync gives locked=1.
REQ-024 Reset mid-byte: rst at frame 5, then a clean 32-bit stream -> only the new bytes appear; no stale out_valid.
REQ-025 With TDM_DEMUX_ERRCNT_EN: 300 forced sync errors -> err_cnt=8'hFF. Reset -> err_cnt=0.
